// File: rtl/ibex_ex_imd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ex_imd_ctrl
// Purpose  : ID-side control for multi-cycle EX operations and owner of the
//            two 34-bit intermediate value registers used by EX.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_ex_imd_ctrl #(
    parameter int unsigned CntWidth = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_req_i,
    input  logic                mult_sel_i,
    input  logic                div_sel_i,
    input  logic                kill_i,
    input  logic                wb_ready_i,
    input  logic                ex_valid_i,
    input  logic [1:0]          imd_val_we_i,
    input  logic [33:0]         imd_val_d_i [2],
    output logic [33:0]         imd_val_q_o [2],
    output logic                instr_first_cycle_o,
    output logic                mult_en_o,
    output logic                div_en_o,
    output logic                multdiv_ready_id_o,
    output logic                ex_done_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] ex_cycle_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = '1;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [33:0]         imd_q [2];
    logic                abort;
    logic                issue;
    logic                active;

    // Dropping ex_req_i mid-instruction is handled as a flush.
    assign abort  = kill_i | ((state_q != IDLE) & ~ex_req_i);
    assign issue  = (state_q == IDLE) & ex_req_i & ~kill_i;
    assign active = rst_ni & ~abort & (((state_q == IDLE) & ex_req_i) | (state_q != IDLE));

    assign instr_first_cycle_o = rst_ni & issue;
    assign mult_en_o           = active & mult_sel_i;
    assign div_en_o            = active & div_sel_i;
    assign multdiv_ready_id_o  = rst_ni & wb_ready_i & ~abort;
    assign ex_done_o           = active & ex_valid_i & wb_ready_i;
    assign busy_o              = (state_q != IDLE);
    assign ex_cycle_cnt_o      = cnt_q;
    assign imd_val_q_o         = imd_q;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_req_i) begin
                        if (ex_valid_i) state_d = wb_ready_i ? IDLE : HOLD;
                        else            state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (ex_valid_i) state_d = wb_ready_i ? IDLE : HOLD;
                end
                HOLD: begin
                    if (wb_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imd_q[0] <= '0;
            imd_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (imd_val_we_i[i] && active) imd_q[i] <= imd_val_d_i[i];
            end
        end
    end

    a_sel_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mult_sel_i && div_sel_i));
    a_done_active : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ex_done_o |-> active);
    a_hold_stays : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((state_q == HOLD) && !wb_ready_i && !abort) |=> (state_q == HOLD));
    a_hold_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((state_q == HOLD) && wb_ready_i && !abort) |-> ex_valid_i);

endmodule
`default_nettype wire
